// File: rtl/scope_capture_buffer.sv
// Multi-channel triggered capture ring: per-channel circular RAMs, level/edge trigger with pre-trigger depth,
// frozen frame read back trigger-aligned over the MCU bus. Samples never stall; bus_rdata is registered (1 cycle).
module scope_capture_buffer #(
  parameter int CH_NUM     = 2,
  parameter int ADC_WIDTH  = 12,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CH_NUM*ADC_WIDTH-1:0]   adc_data,
  input  logic                          adc_valid,
  input  logic                          bus_en,
  input  logic                          bus_wr,
  input  logic [ADDR_WIDTH-1:0]         bus_addr,
  input  logic [DATA_WIDTH-1:0]         bus_wdata,
  output logic [DATA_WIDTH-1:0]         bus_rdata,
  output logic                          irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_LEVEL   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_PRETRIG = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_SAMPLE  = ADDR_WIDTH'('h800);
  localparam logic [DATA_WIDTH-1:0] PT_MAX    = DATA_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PREFILL = 3'd1, S_ARMED = 3'd2, S_POST = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t                state;
  logic                  done;
  logic                  arm_q, auto_q, fall_q;
  logic [1:0]            trig_ch_q;
  logic [ADC_WIDTH-1:0]  level_q;
  logic [AW-1:0]         pretrig_q;
  logic                  fall_s;
  logic [1:0]            trig_ch_s;
  logic [ADC_WIDTH-1:0]  level_s;
  logic [AW-1:0]         pretrig_s;
  logic [AW-1:0]         wr_ptr, start_ptr;
  logic [PW-1:0]         cnt;
  logic [ADC_WIDTH-1:0]  prev;
  logic                  prev_vld;

  logic [ADC_WIDTH-1:0]  mem [CH_NUM][DEPTH];

  logic                  wr_ctrl, wr_status, bus_blk, capturing, smp_take, arm_phase, hit;
  logic [ADC_WIDTH-1:0]  cur;
  logic [PW-1:0]         post_len, cnt_inc;
  logic [ADDR_WIDTH-1:0] smp_off;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign wr_ctrl   = bus_en && bus_wr && (bus_addr == A_CTRL);
  assign wr_status = bus_en && bus_wr && (bus_addr == A_STATUS);
  // A CTRL/STATUS write owns the cycle: the coincident sample is dropped so it can neither trigger nor complete.
  assign bus_blk   = wr_ctrl || wr_status;
  assign capturing = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);
  assign smp_take  = adc_valid && capturing && !bus_blk;
  assign arm_phase = (state == S_ARMED) || ((state == S_PREFILL) && (cnt == {1'b0, pretrig_s}));
  assign post_len  = PW'(DEPTH) - {1'b0, pretrig_s};
  assign cnt_inc   = cnt + PW'(1);
  assign irq       = done;

  always_comb begin
    cur = '0;
    for (int c = 0; c < CH_NUM; c++)
      if (trig_ch_s == 2'(c)) cur = adc_data[c*ADC_WIDTH +: ADC_WIDTH];
  end

  assign hit = prev_vld && (fall_s ? (prev > level_s && cur <= level_s)
                                   : (prev < level_s && cur >= level_s));

  always_ff @(posedge clk) begin
    if (smp_take)
      for (int c = 0; c < CH_NUM; c++)
        mem[c][wr_ptr] <= adc_data[c*ADC_WIDTH +: ADC_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      arm_q     <= 1'b0;
      auto_q    <= 1'b0;
      fall_q    <= 1'b0;
      trig_ch_q <= '0;
      level_q   <= '0;
      pretrig_q <= '0;
      fall_s    <= 1'b0;
      trig_ch_s <= '0;
      level_s   <= '0;
      pretrig_s <= '0;
      wr_ptr    <= '0;
      start_ptr <= '0;
      cnt       <= '0;
      prev      <= '0;
      prev_vld  <= 1'b0;
    end else begin
      if (bus_en && bus_wr) begin
        case (bus_addr)
          A_CTRL: begin
            arm_q     <= bus_wdata[0];
            auto_q    <= bus_wdata[1];
            fall_q    <= bus_wdata[2];
            trig_ch_q <= bus_wdata[5:4];
          end
          A_LEVEL:   level_q   <= bus_wdata[ADC_WIDTH-1:0];
          A_PRETRIG: pretrig_q <= (bus_wdata > PT_MAX) ? '1 : bus_wdata[AW-1:0];
          default: ;
        endcase
      end

      if (smp_take) begin
        wr_ptr   <= wr_ptr + AW'(1);
        prev     <= cur;
        prev_vld <= 1'b1;
      end

      if (wr_ctrl && !bus_wdata[0]) begin
        state <= S_IDLE;
        done  <= 1'b0;
      end else if (wr_ctrl && state == S_IDLE) begin
        state     <= S_PREFILL;
        wr_ptr    <= '0;
        start_ptr <= '0;
        cnt       <= '0;
        prev_vld  <= 1'b0;
        fall_s    <= bus_wdata[2];
        trig_ch_s <= bus_wdata[5:4];
        level_s   <= level_q;
        pretrig_s <= pretrig_q;
      end else if (wr_ctrl && bus_wdata[3] && arm_phase) begin
        // Forced trigger: the next accepted sample lands at wr_ptr and becomes frame index PRETRIG.
        state     <= S_POST;
        start_ptr <= wr_ptr - pretrig_s;
        cnt       <= '0;
      end else if (wr_status) begin
        if (bus_wdata[0]) begin
          done <= 1'b0;
          if (state == S_DONE) begin
            if (auto_q) begin
              state     <= S_PREFILL;
              wr_ptr    <= '0;
              start_ptr <= '0;
              cnt       <= '0;
              prev_vld  <= 1'b0;
              fall_s    <= fall_q;
              trig_ch_s <= trig_ch_q;
              level_s   <= level_q;
              pretrig_s <= pretrig_q;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      end else if (smp_take && arm_phase) begin
        if (hit) begin
          start_ptr <= wr_ptr - pretrig_s;
          if (post_len == PW'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_POST;
            cnt   <= PW'(1);
          end
        end else begin
          state <= S_ARMED;
        end
      end else if (smp_take && state == S_PREFILL) begin
        cnt <= cnt_inc;
        if (cnt_inc == {1'b0, pretrig_s}) state <= S_ARMED;
      end else if (smp_take && state == S_POST) begin
        cnt <= cnt_inc;
        if (cnt_inc == post_len) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
      end else if (arm_phase && state == S_PREFILL) begin
        state <= S_ARMED;
      end
    end
  end

  assign smp_off = bus_addr - A_SAMPLE;
  assign rd_idx  = start_ptr + smp_off[AW-1:0];

  always_comb begin
    rd_mux = '0;
    if (bus_addr >= A_SAMPLE) begin
      for (int c = 0; c < CH_NUM; c++)
        if (smp_off[ADDR_WIDTH-1:AW] == (ADDR_WIDTH-AW)'(c)) rd_mux = DATA_WIDTH'(mem[c][rd_idx]);
    end else begin
      case (bus_addr)
        A_CTRL:    rd_mux = DATA_WIDTH'({trig_ch_q, 1'b0, fall_q, auto_q, arm_q});
        A_LEVEL:   rd_mux = DATA_WIDTH'(level_q);
        A_PRETRIG: rd_mux = DATA_WIDTH'(pretrig_q);
        A_STATUS:  rd_mux = DATA_WIDTH'({state, done});
        default:   rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bus_rdata <= '0;
    else if (bus_en && !bus_wr) bus_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer: ramp/square-wave captures, force, rearm, disarm, collision, reset.
module tb_scope_capture_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        bus_en = 1'b0;
  logic        bus_wr = 1'b0;
  logic [11:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic [15:0] bus_rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  scope_capture_buffer #(.CH_NUM(2), .ADC_WIDTH(12), .DEPTH(512), .DATA_WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .bus_en(bus_en), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk); bus_en = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk); bus_en = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [15:0] d);
    @(negedge clk); bus_en = 1'b1; bus_wr = 1'b0; bus_addr = a;
    @(negedge clk); bus_en = 1'b0; d = bus_rdata;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic push(input logic [11:0] c0, input logic [11:0] c1);
    @(negedge clk); adc_valid = 1'b1; adc_data = {c1, c0};
    @(negedge clk); adc_valid = 1'b0;
  endtask

  function automatic logic [11:0] sq(input int k);
    return ((k % 8) < 4) ? 12'hFFF : 12'h000;
  endfunction

  initial begin
    int last;

    // reset state
    #12;
    check("rst_rdata", 32'(bus_rdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    read_check("rst_status", 12'h003, 16'h0000);
    read_check("rst_ctrl", 12'h000, 16'h0000);
    read_check("rst_pretrig", 12'h002, 16'h0000);
    read_check("rst_level", 12'h001, 16'h0000);

    // rising trigger on a ramp
    bus_write(12'h002, 16'd100);
    bus_write(12'h001, 16'h0800);
    bus_write(12'h000, 16'h0001);
    read_check("ramp_prefill", 12'h003, 16'h0002);
    last = -1;
    for (int v = 0; v < 4096; v++) begin
      push(12'(v), 12'(12'hFFF - v));
      if (irq) begin last = v; break; end
    end
    check("ramp_last_sample", 32'(last), 32'h99B);
    check("ramp_irq", 32'(irq), 32'h1);
    read_check("ramp_status_done", 12'h003, 16'h0009);
    read_check("ramp_s100", 12'h800 + 12'd100, 16'h0800);
    read_check("ramp_s0", 12'h800, 16'h079C);
    read_check("ramp_s511", 12'h800 + 12'd511, 16'h099B);
    read_check("ramp_ch1_s0", 12'hA00, 16'h0863);
    read_check("unmapped_ch2", 12'hC00, 16'h0000);
    read_check("unmapped_reg", 12'h010, 16'h0000);
    push(12'h123, 12'h456);
    push(12'h123, 12'h456);
    read_check("done_frozen_s0", 12'h800, 16'h079C);

    // clear without auto-rearm
    bus_write(12'h003, 16'h0001);
    check("clr_irq_drop", 32'(irq), 32'h0);
    read_check("clr_status_idle", 12'h003, 16'h0000);

    // PRETRIG clamp
    bus_write(12'h002, 16'hFFFF);
    read_check("pretrig_clamp", 12'h002, 16'h01FF);

    // falling edge on channel 1 with auto-rearm
    bus_write(12'h002, 16'd8);
    bus_write(12'h001, 16'h0400);
    bus_write(12'h000, 16'h0017);
    read_check("fall_ctrl_rb", 12'h000, 16'h0017);
    for (int frame = 0; frame < 2; frame++) begin
      last = -1;
      for (int k = 0; k < 2000; k++) begin
        push(12'(k), sq(k));
        if (irq) begin last = k; break; end
      end
      check($sformatf("fall_last_f%0d", frame), 32'(last), 32'd515);
      read_check($sformatf("fall_ch1_s8_f%0d", frame), 12'hA00 + 12'd8, 16'h0000);
      read_check($sformatf("fall_ch0_s8_f%0d", frame), 12'h800 + 12'd8, 16'h000C);
      if (frame == 0) begin
        read_check("fall_ch1_s7", 12'hA00 + 12'd7, 16'h0FFF);
        read_check("fall_ch0_s0", 12'h800, 16'h0004);
        read_check("fall_ch0_s511", 12'h800 + 12'd511, 16'h0203);
        bus_write(12'h003, 16'h0001);
        check("rearm_irq_drop", 32'(irq), 32'h0);
        read_check("rearm_status_prefill", 12'h003, 16'h0002);
      end
    end
    bus_write(12'h000, 16'h0000);
    check("disarm_done_irq", 32'(irq), 32'h0);
    read_check("disarm_done_status", 12'h003, 16'h0000);

    // force with PRETRIG=0
    bus_write(12'h002, 16'd0);
    bus_write(12'h000, 16'h0001);
    for (int j = 0; j < 3; j++) push(12'h100, 12'h0);
    read_check("force_armed", 12'h003, 16'h0004);
    bus_write(12'h000, 16'h0009);
    read_check("force_post", 12'h003, 16'h0006);
    read_check("force_ctrl_rb", 12'h000, 16'h0001);
    last = -1;
    for (int j = 0; j < 1000; j++) begin
      push(12'(12'h200 + j), 12'h0);
      if (irq) begin last = j; break; end
    end
    check("force_len", 32'(last), 32'd511);
    read_check("force_s0", 12'h800, 16'h0200);
    read_check("force_s511", 12'h800 + 12'd511, 16'h03FF);
    bus_write(12'h003, 16'h0001);
    read_check("force_clr_idle", 12'h003, 16'h0000);

    // disarm during POST
    bus_write(12'h002, 16'd4);
    bus_write(12'h000, 16'h0001);
    for (int j = 0; j < 5; j++) push(12'h000, 12'h0);
    push(12'h500, 12'h0);
    read_check("dis_post", 12'h003, 16'h0006);
    bus_write(12'h000, 16'h0000);
    read_check("dis_idle", 12'h003, 16'h0000);
    for (int j = 0; j < 600; j++) push(12'h500, 12'h0);
    check("dis_irq", 32'(irq), 32'h0);

    // CTRL write colliding with a trigger sample
    bus_write(12'h000, 16'h0001);
    for (int j = 0; j < 5; j++) push(12'h000, 12'h0);
    read_check("coll_armed_pre", 12'h003, 16'h0004);
    @(negedge clk);
    adc_valid = 1'b1; adc_data = {12'h0, 12'h500};
    bus_en = 1'b1; bus_wr = 1'b1; bus_addr = 12'h000; bus_wdata = 16'h0001;
    @(negedge clk);
    adc_valid = 1'b0; bus_en = 1'b0; bus_wr = 1'b0;
    read_check("coll_no_capture", 12'h003, 16'h0004);
    check("coll_irq", 32'(irq), 32'h0);

    // asynchronous reset while ARMED
    read_check("rst_pre_ctrl", 12'h000, 16'h0001);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_rdata", 32'(bus_rdata), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    read_check("arst_status", 12'h003, 16'h0000);
    read_check("arst_ctrl", 12'h000, 16'h0000);
    read_check("arst_level", 12'h001, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
